// File: rtl/isp_frame_sequencer_pkg.sv
// Shared ISP definitions: pixel/mode widths, Bayer color codes, sequencer states.
package isp_frame_sequencer_pkg;

    localparam int unsigned COLOR_DEPTH   = 8;
    localparam int unsigned COLOR_BIT_CNT = 2;
    localparam int unsigned MODE_BIT_CNT  = 2;

    localparam logic [COLOR_BIT_CNT-1:0] VOID  = 2'd0;
    localparam logic [COLOR_BIT_CNT-1:0] RED   = 2'd1;
    localparam logic [COLOR_BIT_CNT-1:0] GREEN = 2'd2;
    localparam logic [COLOR_BIT_CNT-1:0] BLUE  = 2'd3;

    localparam logic [MODE_BIT_CNT-1:0] MODE_IDLE = 2'd0;
    localparam logic [MODE_BIT_CNT-1:0] MODE_P1   = 2'd1;
    localparam logic [MODE_BIT_CNT-1:0] MODE_P2   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CFG1, ST_PASS1, ST_WAIT1, ST_CFG2, ST_PASS2, ST_WAIT2, ST_DONE
    } seq_state_e;

    // Sideband that travels with each emitted pixel
    typedef struct packed {
        logic                     valid;
        logic [COLOR_BIT_CNT-1:0] color;
        logic                     last_col;
        logic                     last_pic;
    } pix_tag_t;

    localparam pix_tag_t TAG_IDLE = '{valid: 1'b0, color: VOID, last_col: 1'b0, last_pic: 1'b0};

    // RGGB mosaic lookup from row/column parity
    function automatic logic [COLOR_BIT_CNT-1:0] bayer_color(input logic row_odd, input logic col_odd);
        case ({row_odd, col_odd})
            2'b00:   return RED;
            2'b11:   return BLUE;
            default: return GREEN;
        endcase
    endfunction

endpackage

// File: rtl/isp_raster_counter.sv
// Raster read-address counter with Bayer color and end-of-row/frame flags for the current address.
module isp_raster_counter
    import isp_frame_sequencer_pkg::*;
#(
    parameter int unsigned W_LOG2 = 2,
    parameter int unsigned H_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     step,
    output logic [W_LOG2+H_LOG2-1:0] addr,
    output logic [COLOR_BIT_CNT-1:0] color_c,
    output logic                     last_col_c,
    output logic                     last_pic_c
);

    localparam int unsigned AW = W_LOG2 + H_LOG2;

    // Power-of-two frame size lets the counter wrap to 0 after W*H-1 on its own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (step) begin
            addr <= addr + AW'(1);
        end
    end

    always_comb begin
        color_c    = bayer_color(addr[W_LOG2], addr[0]);
        last_col_c = &addr[W_LOG2-1:0];
        last_pic_c = &addr;
    end

endmodule

// File: rtl/isp_frame_sequencer.sv
// Two-pass frame sequencer: configures the pipeline mode, streams the frame twice and waits for completion.
module isp_frame_sequencer
    import isp_frame_sequencer_pkg::*;
#(
    parameter int unsigned W_LOG2  = 2,
    parameter int unsigned H_LOG2  = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     ready,
    output logic                     rd_en,
    output logic [W_LOG2+H_LOG2-1:0] rd_addr,
    input  logic [COLOR_DEPTH-1:0]   rd_data,
    output logic [COLOR_DEPTH-1:0]   pixel_out,
    output logic                     valid_out,
    output logic [COLOR_BIT_CNT-1:0] color_out,
    output logic                     last_col_out,
    output logic                     last_pic_out,
    output logic [MODE_BIT_CNT-1:0]  mode_out,
    input  logic                     pipe_finish,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    seq_state_e               state, state_d;
    logic [TW-1:0]            timer, timer_d;
    logic                     err_d;
    logic                     clear_cnt;
    logic [MODE_BIT_CNT-1:0]  mode_d;
    logic [COLOR_BIT_CNT-1:0] color_c;
    logic                     last_col_c, last_pic_c;
    pix_tag_t                 tag;

    // Reads are issued in the same cycle the pipeline signals ready
    assign rd_en = ((state == ST_PASS1) || (state == ST_PASS2)) && ready;

    isp_raster_counter #(
        .W_LOG2 (W_LOG2),
        .H_LOG2 (H_LOG2)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_cnt),
        .step       (rd_en),
        .addr       (rd_addr),
        .color_c    (color_c),
        .last_col_c (last_col_c),
        .last_pic_c (last_pic_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mode_out <= MODE_IDLE;
            tag      <= TAG_IDLE;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            err      <= err_d;
            busy     <= (state_d != ST_IDLE);
            done     <= (state_d == ST_DONE);
            mode_out <= mode_d;
            tag      <= rd_en ? '{valid: 1'b1, color: color_c, last_col: last_col_c, last_pic: last_pic_c}
                              : TAG_IDLE;
        end
    end

    // Memory data lands one cycle after rd_en, alongside the registered tag
    assign valid_out    = tag.valid;
    assign pixel_out    = tag.valid ? rd_data : '0;
    assign color_out    = tag.color;
    assign last_col_out = tag.last_col;
    assign last_pic_out = tag.last_pic;

    always_comb begin
        state_d   = state;
        err_d     = err;
        clear_cnt = 1'b0;
        timer_d   = '0;
        mode_d    = MODE_IDLE;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CFG1;
                    err_d     = 1'b0;
                    clear_cnt = 1'b1;
                end
            end
            ST_CFG1:  if (timer == TW'(1)) state_d = ST_PASS1;
            ST_PASS1: if (rd_en && last_pic_c) state_d = ST_WAIT1;
            ST_WAIT1: begin
                if (pipe_finish) begin
                    state_d   = ST_CFG2;
                    clear_cnt = 1'b1;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_CFG2:  if (timer == TW'(1)) state_d = ST_PASS2;
            ST_PASS2: if (rd_en && last_pic_c) state_d = ST_WAIT2;
            ST_WAIT2: begin
                if (pipe_finish) begin
                    state_d = ST_DONE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Timer restarts on every state change and only runs in CFG/WAIT
        if ((state_d == state) &&
            ((state == ST_CFG1) || (state == ST_CFG2) || (state == ST_WAIT1) || (state == ST_WAIT2))) begin
            timer_d = timer + TW'(1);
        end

        case (state_d)
            ST_CFG1, ST_PASS1, ST_WAIT1: mode_d = MODE_P1;
            ST_CFG2, ST_PASS2, ST_WAIT2: mode_d = MODE_P2;
            default:                     mode_d = MODE_IDLE;
        endcase
    end

endmodule
